// File: rtl/regressor_buffer_if.sv
// Sample stream into the regressor buffer and the regressor/tag outputs
// it presents to the dot-product stage and the RLS controller.
interface regressor_buffer_if #(
  parameter int N     = 2,
  parameter int nBits = 32,
  parameter int log   = 2
);
  // Handshake: a sample transfers on a rising edge where s_valid & s_ready.
  // s_valid must stay high with s_data stable until then.
  // s_ready is low while hold or flush is asserted.
  logic               flush;
  logic               hold;
  logic               s_valid;
  logic               s_ready;
  logic [nBits-1:0]   s_data;
  logic [N*nBits-1:0] vec;
  logic               vec_valid;
  logic               vec_full;
  logic [log:0]       fill_count;
  logic               res_valid;

  modport master (
    output flush, hold, s_valid, s_data,
    input  s_ready, vec, vec_valid, vec_full, fill_count, res_valid
  );

  modport slave (
    input  flush, hold, s_valid, s_data,
    output s_ready, vec, vec_valid, vec_full, fill_count, res_valid
  );
endinterface

// File: rtl/regressor_buffer.sv
// N-tap delay line of sign-magnitude samples feeding the RLS dot-product
// stage, with warm-up counting, flush and a latency-matched result tag.
module regressor_buffer #(
  parameter int N     = 2,
  parameter int nBits = 32,
  parameter int log   = 2,
  parameter int LAT   = 4
) (
  input logic             clk,
  input logic             rst_n,
  regressor_buffer_if.slave bus
);

  localparam logic [log:0] FULL = (log+1)'(N);

  logic [nBits-1:0]   taps [N];
  logic [N*nBits-1:0] vec_packed;
  logic [log:0]       fill_count;
  logic               vec_valid;
  logic [LAT-1:0]     tag;
  logic               accept;

  assign bus.s_ready = ~bus.hold & ~bus.flush;
  assign accept      = bus.s_valid & bus.s_ready;

  // Taps move only on accept or flush; samples are stored bit-for-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) taps[i] <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < N; i++) taps[i] <= '0;
    end else if (accept) begin
      taps[0] <= bus.s_data;
      for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
    end
  end

  // vec_valid marks accepts that leave the line fully populated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count <= '0;
      vec_valid  <= 1'b0;
    end else if (bus.flush) begin
      fill_count <= '0;
      vec_valid  <= 1'b0;
    end else begin
      vec_valid <= accept && (fill_count >= FULL - 1'b1);
      if (accept && (fill_count != FULL)) fill_count <= fill_count + 1'b1;
    end
  end

  // Tag pipeline runs every cycle, hold included, since the datapath is free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else if (bus.flush) begin
      tag <= '0;
    end else begin
      tag[0] <= vec_valid;
      for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];
    end
  end

  always_comb begin
    vec_packed = '0;
    for (int i = 0; i < N; i++) vec_packed[N*nBits-1-i*nBits -: nBits] = taps[i];
  end

  assign bus.vec        = vec_packed;
  assign bus.vec_valid  = vec_valid;
  assign bus.vec_full   = (fill_count == FULL);
  assign bus.fill_count = fill_count;
  assign bus.res_valid  = tag[LAT-1];

endmodule

// File: tb/tb_regressor_buffer.sv
// Bench for regressor_buffer: table-driven N=2/LAT=4 instance with a
// res_valid scoreboard, plus hand sequences for async reset and N=4/LAT=1.
module tb_regressor_buffer;

  localparam int LAT_A = 4;

  logic clk;
  logic rst_n;

  regressor_buffer_if #(.N(2), .nBits(32), .log(2)) a_if ();
  regressor_buffer_if #(.N(4), .nBits(32), .log(2)) b_if ();

  regressor_buffer #(.N(2), .nBits(32), .log(2), .LAT(LAT_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  regressor_buffer #(.N(4), .nBits(32), .log(2), .LAT(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        hold;
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [2:0]  fill;
    logic        vv;
  } vec_t;

  vec_t        tbl [$];
  logic [0:0]  exp_q [$];
  int          checks;
  int          failures;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic ho, input logic va, input logic [31:0] d,
                     input logic rdy, input logic [31:0] t0, input logic [31:0] t1,
                     input logic [2:0] fill, input logic vv);
    vec_t r;
    r.flush = fl; r.hold = ho; r.valid = va; r.data = d; r.ready = rdy;
    r.t0 = t0; r.t1 = t1; r.fill = fill; r.vv = vv;
    tbl.push_back(r);
  endtask

  task automatic reset_scoreboard();
    exp_q.delete();
    for (int i = 0; i < LAT_A; i++) exp_q.push_back(1'b0);
  endtask

  // driver: apply one record for one clock, check registered outputs after the edge
  task automatic apply(input vec_t v);
    a_if.flush   = v.flush;
    a_if.hold    = v.hold;
    a_if.s_valid = v.valid;
    a_if.s_data  = v.data;
    #1;
    check("s_ready", a_if.s_ready, v.ready);
    @(posedge clk);
    #1;
    check("vec", a_if.vec, {v.t0, v.t1});
    check("fill_count", a_if.fill_count, v.fill);
    check("vec_valid", a_if.vec_valid, v.vv);
    check("vec_full", a_if.vec_full, (v.fill == 3'd2));
    if (v.flush) foreach (exp_q[i]) exp_q[i] = 1'b0;
    check("res_valid", a_if.res_valid, exp_q.pop_front());
    exp_q.push_back(v.vv);
    a_if.flush   = 1'b0;
    a_if.hold    = 1'b0;
    a_if.s_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag_name);
    check({tag_name, "_vec_a"}, a_if.vec, 128'd0);
    check({tag_name, "_fill_a"}, a_if.fill_count, 128'd0);
    check({tag_name, "_vv_a"}, a_if.vec_valid, 128'd0);
    check({tag_name, "_full_a"}, a_if.vec_full, 128'd0);
    check({tag_name, "_res_a"}, a_if.res_valid, 128'd0);
    check({tag_name, "_vec_b"}, b_if.vec, 128'd0);
    check({tag_name, "_fill_b"}, b_if.fill_count, 128'd0);
  endtask

  initial begin
    int          phase2;
    logic [127:0] exp_b;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a_if.flush = 1'b0; a_if.hold = 1'b0; a_if.s_valid = 1'b0; a_if.s_data = '0;
    b_if.flush = 1'b0; b_if.hold = 1'b0; b_if.s_valid = 1'b0; b_if.s_data = '0;

    // warm-up
    add(0,0,1,32'h3,        1, 32'h3,        32'h0,        3'd1, 0);
    add(0,0,1,32'h80000005, 1, 32'h80000005, 32'h3,        3'd2, 1);
    for (int i = 0; i < 4; i++) add(0,0,0,32'h0, 1, 32'h80000005, 32'h3, 3'd2, 0);
    // streaming 1..5
    add(0,0,1,32'h1, 1, 32'h1, 32'h80000005, 3'd2, 1);
    for (int k = 2; k <= 5; k++) add(0,0,1,32'(k), 1, 32'(k), 32'(k-1), 3'd2, 1);
    add(0,0,0,32'h0, 1, 32'h5, 32'h4, 3'd2, 0);
    // hold with a pending sample, then release
    for (int i = 0; i < 3; i++) add(0,1,1,32'h7, 0, 32'h5, 32'h4, 3'd2, 0);
    add(0,0,1,32'h7, 1, 32'h7, 32'h5, 3'd2, 1);
    add(0,0,0,32'h0, 1, 32'h7, 32'h5, 3'd2, 0);
    // -0 stored verbatim, then flush with s_valid high while its tag is in flight
    add(0,0,1,32'h80000000, 1, 32'h80000000, 32'h7, 3'd2, 1);
    add(0,0,0,32'h0, 1, 32'h80000000, 32'h7, 3'd2, 0);
    add(1,0,1,32'h9, 0, 32'h0, 32'h0, 3'd0, 0);
    for (int i = 0; i < 4; i++) add(0,0,0,32'h0, 1, 32'h0, 32'h0, 3'd0, 0);
    add(0,0,1,32'hA, 1, 32'hA, 32'h0, 3'd1, 0);
    add(0,0,1,32'hB, 1, 32'hB, 32'hA, 3'd2, 1);
    phase2 = tbl.size();
    // warm-up again after the mid-stream reset
    add(0,0,1,32'h11, 1, 32'h11, 32'h0,  3'd1, 0);
    add(0,0,1,32'h22, 1, 32'h22, 32'h11, 3'd2, 1);
    for (int i = 0; i < 6; i++) add(0,0,0,32'h0, 1, 32'h22, 32'h11, 3'd2, 0);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    reset_scoreboard();

    for (int i = 0; i < phase2; i++) apply(tbl[i]);

    // async reset between edges while full
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1;
    rst_n = 1'b1;
    reset_scoreboard();

    for (int i = phase2; i < tbl.size(); i++) apply(tbl[i]);

    // N=4, LAT=1 instance
    for (int k = 1; k <= 4; k++) begin
      b_if.s_valid = 1'b1;
      b_if.s_data  = 32'(k);
      @(posedge clk);
      #1;
      check("b_fill", b_if.fill_count, 128'(k));
      check("b_vec_valid", b_if.vec_valid, (k == 4));
      check("b_res_valid", b_if.res_valid, 128'd0);
    end
    b_if.s_valid = 1'b0;
    exp_b = {32'd4, 32'd3, 32'd2, 32'd1};
    check("b_vec", b_if.vec, exp_b);
    check("b_full", b_if.vec_full, 128'd1);
    @(posedge clk);
    #1;
    check("b_vec_valid_after", b_if.vec_valid, 128'd0);
    check("b_res_valid_lat", b_if.res_valid, 128'd1);
    @(posedge clk);
    #1;
    check("b_res_valid_end", b_if.res_valid, 128'd0);
    check("b_vec_stable", b_if.vec, exp_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regressor_buffer.md
Name: regressor_buffer

Overview:
- Upstream feeder for the RLS vector-product stage. Accepts one sign-magnitude scalar sample per handshake and maintains an N-tap delay line of the most recent samples.
- Presents the taps as a packed N*nBits regressor vector in the packing the dot-product stage consumes.
- Generates a latency-matched valid tag, so the RLS controller knows which dot-product result belongs to which accepted sample.
- Also handles warm-up (the first N-1 samples) and flush between adaptation runs.

Parameters:
- N, 2: number of taps (vector length); N >= 2.
- nBits, 32: sample width; bit nBits-1 = sign, bits nBits-2:0 = magnitude.
- log, 2: fill counter width minus 1; 2^log >= N is required.
- LAT, 4: cycles from vec_valid to a valid dot-product result (multiplier plus adder-tree latency); LAT >= 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous clear of taps, fill count and tag pipeline.
- hold, input, 1: controller stall (weight update in progress); blocks acceptance.
- s_valid, input, 1: s_data is valid.
- s_ready, output, 1: the buffer can accept a sample.
- s_data, input, nBits: new sample, sign-magnitude.
- vec, output, N*nBits: packed taps; element i at vec[N*nBits-1-i*nBits -: nBits], element 0 = newest.
- vec_valid, output, 1: one-cycle pulse when vec holds a fully populated new vector.
- vec_full, output, 1: fill_count == N.
- fill_count, output, log+1: number of valid taps, 0..N.
- res_valid, output, 1: vec_valid delayed by exactly LAT cycles.

Behaviour:
- Reset, asynchronous while rst_n = 0: all taps 0, fill_count = 0, vec_valid = 0, vec_full = 0, res_valid = 0, tag pipeline cleared.
- s_ready is combinational: s_ready = ~hold & ~flush.
- Accept: occurs on a rising edge when s_valid & s_ready. On accept:
  - tap[0] <= s_data.
  - tap[i] <= tap[i-1] for i = 1..N-1.
  - tap[N-1]'s old value is discarded.
- Taps change only on an accept or a flush. Otherwise vec holds its value, and it stays stable between accepts.
- Taps are stored verbatim: no sign or magnitude manipulation, and -0 is stored as given.
- fill_count: increments on accept and saturates at N.
- vec_valid: registered. It is 1 in the cycle after an accept whose post-accept fill_count == N, i.e. the N-th and every later accept. Otherwise it is 0.
  - Warm-up accepts 1..N-1 produce no vec_valid.
- Tag pipeline: an LAT-stage shift register fed by vec_valid; res_valid is its last stage. It advances every cycle regardless of hold, because the downstream datapath is free-running.
- flush: on a rising edge with flush = 1:
  - taps <= 0, fill_count <= 0, vec_valid <= 0.
  - All tag stages <= 0, so in-flight results are not flagged.
  - No sample is accepted that cycle.
- Simultaneous events:
  - flush & s_valid: flush wins and the sample is not accepted (s_ready = 0).
  - hold & s_valid: no accept; the sample must be held by the producer.
  - hold does not clear state.
- Back-to-back accepts are legal every cycle: vec_valid may stay high for consecutive cycles and res_valid mirrors that pattern LAT cycles later.
- Reset asserted mid-operation clears everything immediately. On rst_n release, the first rising edge may accept a sample.
- Area: the block holds N*nBits tap flops, log+1 counter bits, LAT tag flops and one vec_valid flop. There is no arithmetic in the datapath.

Test Plan:
- Reset/warm-up (N=2, nBits=32, LAT=4):
  - Stimulus: rst_n pulse, then accept 0x00000003 with hold = 0.
  - Required: vec = {0x00000003, 0x00000000}, fill_count = 1, vec_valid never asserts.
  - Stimulus: accept 0x80000005.
  - Required: vec = {0x80000005, 0x00000003}, fill_count = 2, vec_full = 1, vec_valid = 1 for one cycle, res_valid = 1 exactly 4 cycles later.
- Streaming:
  - Stimulus: after fill, s_valid held high for 5 cycles with samples 1..5.
  - Required: vec_valid high 5 consecutive cycles, vec = {k, k-1} per cycle, res_valid high 5 consecutive cycles starting 4 cycles later, fill_count stays 2.
- Hold:
  - Stimulus: assert hold for 3 cycles with s_valid = 1 and s_data = 0x7.
  - Required: s_ready = 0, vec unchanged, no vec_valid.
  - Stimulus: deassert hold.
  - Required: 0x7 accepted on the next edge, vec_valid pulses.
- Flush with in-flight results:
  - Stimulus: accept a sample (vec_valid = 1), then flush 2 cycles later with s_valid = 1.
  - Required: sample not accepted, taps = 0, fill_count = 0, res_valid never asserts for the pre-flush accept.
- Async reset mid-stream:
  - Stimulus: drop rst_n between clock edges while full.
  - Required: all outputs zero immediately without waiting for a clk edge; after release, warm-up restarts with fill_count counting 1, 2.
- Parameter sweep:
  - Stimulus: N=4, log=2, LAT=1, four accepts of 1, 2, 3, 4.
  - Required: vec = {4, 3, 2, 1}, vec_valid only after the 4th accept, res_valid 1 cycle after vec_valid.
